// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequenced 32x32 multiply controller.
// Optional build macro: MUL_SEQ_SIGNED_HI_EN (high-word mode, see mul_seq_ctrl).
package mul_seq_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP,
    ISSUE2,
    CAPT2
  } state_e;

  // Low word of a_lo*b_lo + (a_lo*b_hi + a_hi*b_lo) << 16; everything above bit 31 drops out.
  function automatic logic [DATA_W-1:0] combine_lo(input logic [DATA_W-1:0] p1,
                                                   input logic [DATA_W-1:0] p2,
                                                   input logic [DATA_W-1:0] p3);
    logic [DATA_W-1:0] mid;
    mid = p2 + p3;
    return p1 + {mid[HALF_W-1:0], {HALF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mul_seq_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module mul_seq_rr_arb #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= RR_INIT;
    end else if (advance && (|grant)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the shared three-partial-product multiplier cell with two round-robin requesters.
// Build macro MUL_SEQ_SIGNED_HI_EN adds req_hi and a second cell pass returning product[63:32].
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter logic        RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
`ifdef MUL_SEQ_SIGNED_HI_EN
  input  logic [1:0]        req_hi,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] mc_src1,
  output logic [DATA_W-1:0] mc_src2,
  output logic              mc_en,
  input  logic [DATA_W-1:0] mc_p1,
  input  logic [DATA_W-1:0] mc_p2,
  input  logic [DATA_W-1:0] mc_p3,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [DATA_W-1:0] a_q, b_q, data_q;
  logic              id_q;
  logic [CNT_W-1:0]  cnt_q;

  mul_seq_rr_arb #(.RR_INIT(RR_INIT)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];

`ifdef MUL_SEQ_SIGNED_HI_EN
  localparam int unsigned MID_W = 2 * DATA_W - HALF_W + 1;

  logic              hi_q;
  logic [HALF_W:0]   mid_q;
  logic [MID_W-1:0]  mid_full;

  // Only the bits above 31 of the pass-1 sum feed the high word; a_hi*b_hi arrives on p1 in pass 2.
  assign mid_full = MID_W'(mc_p1) + ((MID_W'(mc_p2) + MID_W'(mc_p3)) << HALF_W);

  always_comb begin
    mc_src1 = a_q;
    mc_src2 = b_q;
    if (state_q == ISSUE2 || state_q == CAPT2) begin
      mc_src1 = {{HALF_W{1'b0}}, a_q[DATA_W-1:HALF_W]};
      mc_src2 = {{HALF_W{1'b0}}, b_q[DATA_W-1:HALF_W]};
    end
  end
  assign mc_en = (state_q == ISSUE) || (state_q == ISSUE2);
`else
  assign mc_src1 = a_q;
  assign mc_src2 = b_q;
  assign mc_en   = (state_q == ISSUE);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPT;
`ifdef MUL_SEQ_SIGNED_HI_EN
      CAPT:    state_d = hi_q ? ISSUE2 : RESP;
      ISSUE2:  state_d = CAPT2;
      CAPT2:   state_d = RESP;
`else
      CAPT:    state_d = RESP;
`endif
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef MUL_SEQ_SIGNED_HI_EN
      hi_q    <= 1'b0;
      mid_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= sel ? req1_a : req0_a;
        b_q  <= sel ? req1_b : req0_b;
        id_q <= sel;
`ifdef MUL_SEQ_SIGNED_HI_EN
        hi_q <= req_hi[sel];
`endif
      end
`ifdef MUL_SEQ_SIGNED_HI_EN
      if (state_q == CAPT) begin
        if (hi_q) mid_q <= mid_full[MID_W-1:DATA_W];
        else      data_q <= combine_lo(mc_p1, mc_p2, mc_p3);
      end
      if (state_q == CAPT2) data_q <= DATA_W'(mid_q) + mc_p1;
`else
      if (state_q == CAPT) data_q <= combine_lo(mc_p1, mc_p2, mc_p3);
`endif
      if (state_q == RESP && rsp_ready && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl (default build): reference is plain 64-bit multiplication.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data, mc_src1, mc_src2;
  logic        mc_en;
  logic [31:0] mc_p1 = '0, mc_p2 = '0, mc_p3 = '0;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.CNT_W(16), .RR_INIT(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mc_src1(mc_src1), .mc_src2(mc_src2), .mc_en(mc_en),
    .mc_p1(mc_p1), .mc_p2(mc_p2), .mc_p3(mc_p3),
    .busy(busy), .op_count(op_count)
  );

  // Multiplier cell: 16x16 partial products behind one enabled register stage.
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= mc_src1[15:0]  * mc_src2[15:0];
      mc_p2 <= mc_src1[15:0]  * mc_src2[31:16];
      mc_p3 <= mc_src1[31:16] * mc_src2[15:0];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  logic        rsp_ids[$];
  int          cyc = 0;
  int          acc_cnt[2] = '{0, 0};
  logic        m_last = 1'b1;
  int          m_count = 0;
  logic        in_flight = 1'b0;
  int          mc_en_seen = 0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_id = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: reference arbitration, scoreboard push on accept, pop and compare on response.
  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic        id;
    logic [31:0] a, b;
    exp_t        e;
    if (reset) begin
      sbq.delete();
      m_last     = 1'b1;
      m_count    = 0;
      in_flight  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      if (!in_flight) begin
        if (req_valid == 2'b01)      exp_rdy = 2'b01;
        else if (req_valid == 2'b10) exp_rdy = 2'b10;
        else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("op_count", op_count, m_count);
      chk("busy", busy, in_flight);
      if (mc_en) begin
        mc_en_seen++;
        chk("mc_src1", mc_src1, cur_a);
        chk("mc_src2", mc_src2, cur_b);
      end
      chk("rsp_valid", rsp_valid, in_flight && (cyc - sbq[0].acc_cyc >= 3));
      if (rsp_valid && in_flight) begin
        if (stall_prev) begin
          chk("stall_data", rsp_data, stall_data);
          chk("stall_id", rsp_id, stall_id);
        end
        if (rsp_ready) begin
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_data", rsp_data, sbq[0].data);
          chk("mc_en_once", mc_en_seen, 1);
          rsp_ids.push_back(rsp_id);
          void'(sbq.pop_front());
          in_flight  = 1'b0;
          stall_prev = 1'b0;
          if (m_count < 65535) m_count++;
        end else begin
          stall_prev = 1'b1;
          stall_data = rsp_data;
          stall_id   = rsp_id;
        end
      end
      if (|(exp_rdy & req_valid)) begin
        id        = exp_rdy[1];
        a         = id ? req1_a : req0_a;
        b         = id ? req1_b : req0_b;
        e.id      = id;
        e.data    = 32'(64'(a) * 64'(b));
        e.acc_cyc = cyc;
        sbq.push_back(e);
        m_last     = id;
        in_flight  = 1'b1;
        mc_en_seen = 0;
        cur_a      = a;
        cur_b      = b;
        acc_cnt[id]++;
      end
    end
  end

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin req0_a = a; req0_b = b; end
    else         begin req1_a = a; req1_b = b; end
  endtask

  // Raise one request and hold it until accepted; returns the number of edges waited.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, output int waited);
    int start;
    start = acc_cnt[id];
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    waited = 0;
    while (acc_cnt[id] == start && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid[id] = 1'b0;
    if (acc_cnt[id] == start) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    int seen[2];
    int target;
    reset     = 1'b1;
    req_valid = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mc_src1", mc_src1, 0);
    chk("rst_mc_src2", mc_src2, 0);
    chk("rst_mc_en", mc_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);

    // Reset while the cell result is being captured; the op is dropped.
    @(posedge clk); #1;
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0, w);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_op_count", op_count, 0);
    @(posedge clk); #1;
    issue(0, 32'd3, 32'd5, w);
    chk("accept_after_reset", w, 1);
    drain();
    @(negedge clk);
    chk("first_op_count", op_count, 1);

    @(posedge clk); #1;
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w); drain();
    @(posedge clk); #1;
    issue(0, 32'h0001_0000, 32'h0001_0000, w); drain();
    @(posedge clk); #1;
    issue(1, 32'h0001_2345, 32'h0000_0010, w); drain();

    // Both requesters held valid for four operations.
    @(posedge clk); #1;
    rsp_ids.delete();
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    target  = acc_cnt[0] + acc_cnt[1] + 4;
    set_op(0, rnd32(), rnd32());
    set_op(1, rnd32(), rnd32());
    req_valid = 2'b11;
    for (int c = 0; c < 60 && (acc_cnt[0] + acc_cnt[1]) < target; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          set_op(i, rnd32(), rnd32());
        end
      end
    end
    req_valid = 2'b00;
    drain();
    chk("rr_count", rsp_ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_ids.size()) chk($sformatf("rr_id%0d", i), rsp_ids[i], i % 2);
    end

    // Backpressure: result held five cycles in RESP with a competing request waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(0, rnd32(), rnd32(), w);
    set_op(1, rnd32(), rnd32());
    req_valid[1] = 1'b1;
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1'b1;
    w = acc_cnt[1];
    for (int c = 0; c < 20 && acc_cnt[1] == w; c++) begin
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    drain();

    // Randomized traffic with random result backpressure.
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (acc_cnt[i] != seen[i] || !req_valid[i]) begin
          seen[i] = acc_cnt[i];
          req_valid[i] = $urandom_range(0, 1) == 1;
          set_op(i, rnd32(), rnd32());
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
